key_event_classifier: RTL and testbench

- Consumes the debounced key level from key_filter (key_out, idle high, 0 = pressed).
- Classifies each key gesture into single-cycle event pulses: short press, double click, long press, and auto-repeat while held.
- Drives the UI/menu control logic, which must never see raw edges.
- All timing parameters are in clk cycles.

---
 rtl/key_pkg.sv | 15 +
 rtl/key_edge_detect.sv | 26 ++
 rtl/key_event_classifier.sv | 123 ++++++++++++
 tb/tb_key_event_classifier.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for key gesture classification.
// Debounced key inputs are active-low; KEY_PRESSED names that level.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS    = 3'd1,
    HOLD     = 3'd2,
    GAP      = 3'd3,
    WAIT_REL = 3'd4
  } key_state_t;

  localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_edge_detect.sv
// Registers a debounced key level and flags press (fall) and release (rise) edges.
// The register resets to the released level, so a key held at reset release reads as a press.
module key_edge_detect
  import key_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic fall,
  output logic rise
);

  logic key_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_d <= ~KEY_PRESSED;
    end else begin
      key_d <= key_in;
    end
  end

  assign fall = (key_d != KEY_PRESSED) && (key_in == KEY_PRESSED);
  assign rise = (key_d == KEY_PRESSED) && (key_in != KEY_PRESSED);

endmodule

// File: rtl/key_event_classifier.sv
// Turns a debounced key level into one-cycle gesture events:
// short press, double click, long press and auto-repeat while held.
module key_event_classifier
  import key_pkg::*;
#(
  parameter int LONG_TIME   = 50_000_000,
  parameter int DCLICK_GAP  = 12_500_000,
  parameter int REPEAT_TIME = 5_000_000,
  parameter int CNT_W       = 26
)
(
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic key_busy
);

  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  if ((LONG_TIME < 2) || (DCLICK_GAP < 2) || (REPEAT_TIME < 1) ||
      (longint'(LONG_TIME) > CNT_MAX) || (longint'(DCLICK_GAP) > CNT_MAX) ||
      (longint'(REPEAT_TIME) > CNT_MAX)) begin : g_bad_params
    $error("key_event_classifier: timing parameters out of range or CNT_W too narrow");
  end

  // cnt is 0 in the first cycle of a state. PRESS and GAP are entered one
  // cycle after their edge, so their thresholds sit one lower to land
  // long_press at fall+LONG_TIME and short_press at release+DCLICK_GAP.
  // HOLD is entered together with long_press, so it counts the full period.
  localparam logic [CNT_W-1:0] LONG_THR = CNT_W'(LONG_TIME - 2);
  localparam logic [CNT_W-1:0] GAP_THR  = CNT_W'(DCLICK_GAP - 2);
  localparam logic [CNT_W-1:0] REP_THR  = CNT_W'(REPEAT_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  key_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             fall, rise;
  logic             cnt_clr, timed;
  logic             short_nx, double_nx, long_nx, repeat_nx;

  key_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .fall   (fall),
    .rise   (rise)
  );

  assign timed = (state == PRESS) || (state == HOLD) || (state == GAP);

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    short_nx   = 1'b0;
    double_nx  = 1'b0;
    long_nx    = 1'b0;
    repeat_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) state_next = PRESS;
      end
      PRESS: begin
        if (rise) begin
          state_next = GAP;
        end else if (cnt == LONG_THR) begin
          long_nx    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (rise) begin
          state_next = IDLE;
        end else if (cnt == REP_THR) begin
          repeat_nx = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      GAP: begin
        // A fall on the timeout cycle still counts as the second click.
        if (fall) begin
          double_nx  = 1'b1;
          state_next = WAIT_REL;
        end else if (cnt == GAP_THR) begin
          short_nx   = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_REL: begin
        if (rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      key_busy     <= 1'b0;
    end else begin
      state        <= state_next;
      short_press  <= short_nx;
      double_click <= double_nx;
      long_press   <= long_nx;
      repeat_pulse <= repeat_nx;
      key_busy     <= (state_next != IDLE);
      if (cnt_clr || (state_next != state)) begin
        cnt <= '0;
      end else if (timed && (cnt != CNT_SAT)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_event_classifier.sv
// Bench for key_event_classifier: key waveforms are built per scenario and the
// expected event stream is derived from gesture durations (fall/rise arithmetic).
module tb_key_event_classifier;

  localparam int LONG = 100;
  localparam int GAPT = 50;
  localparam int REP  = 20;
  localparam int MAXN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_in = 1'b1;
  logic short_press, double_click, long_press, repeat_pulse, key_busy;

  always #10 clk = ~clk;

  key_event_classifier #(
    .LONG_TIME   (LONG),
    .DCLICK_GAP  (GAPT),
    .REPEAT_TIME (REP),
    .CNT_W       (26)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .short_press  (short_press),
    .double_click (double_click),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse),
    .key_busy     (key_busy)
  );

  // Packed per-cycle view: {busy, repeat, long, double, short}
  logic       trace[MAXN];
  int         n;
  logic [4:0] obs_v[MAXN];
  logic [4:0] exp_a[MAXN];
  logic [4:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic clear_trace();
    n = 0;
  endtask

  task automatic add_seg(input logic lvl, input int len);
    for (int i = 0; i < len; i++) begin
      trace[n] = lvl;
      n++;
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic prev_level(input int t);
    return (t == 0) ? 1'b1 : trace[t-1];
  endfunction

  function automatic int find_fall(input int s);
    for (int i = s; i < n; i++)
      if (prev_level(i) == 1'b1 && trace[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_rise(input int s);
    for (int i = s; i < n; i++)
      if (prev_level(i) == 1'b0 && trace[i] == 1'b1) return i;
    return -1;
  endfunction

  function automatic void mark(input int c, input int b);
    if (c >= 0 && c < n) exp_a[c][b] = 1'b1;
  endfunction

  function automatic void mark_busy(input int a, input int b);
    for (int i = a; i < b && i < n; i++) exp_a[i][4] = 1'b1;
  endfunction

  function automatic void build_expected();
    int t, f, r, f2, r2;
    for (int i = 0; i < n; i++) exp_a[i] = '0;
    t = 0;
    while (t < n) begin
      f = find_fall(t);
      if (f < 0) break;
      r = find_rise(f + 1);
      if (r < 0) r = n + LONG + GAPT;
      if (r - f >= LONG) begin
        mark(f + LONG, 2);
        for (int k = f + LONG + REP; k <= r && k < n; k += REP) mark(k, 3);
        mark_busy(f + 1, r + 1);
        t = r + 1;
      end else begin
        f2 = find_fall(r + 1);
        if (f2 >= 0 && f2 <= r + GAPT - 1) begin
          mark(f2 + 1, 1);
          r2 = find_rise(f2 + 1);
          if (r2 < 0) r2 = n;
          mark_busy(f + 1, r2 + 1);
          t = r2 + 1;
        end else begin
          mark(r + GAPT, 0);
          mark_busy(f + 1, r + GAPT);
          t = r + GAPT;
        end
      end
    end
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(exp_a[i]);
  endfunction

  // ---------------- driver ----------------
  task automatic start_reset(input logic lvl);
    rst = 1'b1;
    key_in = lvl;
  endtask

  // Holds reset for a few edges, releases it and plays trace[0..n-1], one level per cycle.
  task automatic run_trace();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < n; t++) begin
      key_in = trace[t];
      @(negedge clk);
      obs_v[t] = {key_busy, repeat_pulse, long_press, double_click, short_press};
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] e;
    #2 rst = 1'b1;
    #3;
    checks++;
    if ({key_busy, repeat_pulse, long_press, double_click, short_press} !== 5'b0) begin
      errors++;
      $display("FAIL reset_values: got %b expected 00000",
               {key_busy, repeat_pulse, long_press, double_click, short_press});
    end
    clear_trace();
    add_seg(1'b1, 80);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL idle_after_reset cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
    end
  endtask

  task automatic test_short_press();
    logic [4:0] e;
    start_reset(1'b1);
    clear_trace();
    add_seg(1'b1, 5); add_seg(1'b0, 30); add_seg(1'b1, 200);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL short_press cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
    end
    checks++;
    if (obs_v[85] !== 5'b00001 || obs_v[84] !== 5'b10000) begin
      errors++;
      $display("FAIL short_press_timing: got %b/%b expected 10000/00001", obs_v[84], obs_v[85]);
    end
  endtask

  task automatic test_double_click();
    logic [4:0] e;
    start_reset(1'b1);
    clear_trace();
    add_seg(1'b1, 5); add_seg(1'b0, 30); add_seg(1'b1, 20); add_seg(1'b0, 30); add_seg(1'b1, 100);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL double_click cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
    end
    checks++;
    if (obs_v[56] !== 5'b10010 || obs_v[85] !== 5'b10000 || obs_v[86] !== 5'b00000) begin
      errors++;
      $display("FAIL double_click_timing: got %b %b %b expected 10010 10000 00000",
               obs_v[56], obs_v[85], obs_v[86]);
    end
  endtask

  task automatic test_long_repeat();
    logic [4:0] e;
    start_reset(1'b1);
    clear_trace();
    add_seg(1'b1, 5); add_seg(1'b0, 165); add_seg(1'b1, 100);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL long_repeat cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
    end
    checks++;
    if (obs_v[105] !== 5'b10100 || obs_v[125] !== 5'b11000 || obs_v[165] !== 5'b11000 ||
        obs_v[171] !== 5'b00000) begin
      errors++;
      $display("FAIL long_repeat_timing: got %b %b %b %b expected 10100 11000 11000 00000",
               obs_v[105], obs_v[125], obs_v[165], obs_v[171]);
    end
  endtask

  task automatic test_press_boundary();
    logic [4:0] e;
    for (int len = LONG - 1; len <= LONG; len++) begin
      start_reset(1'b1);
      clear_trace();
      add_seg(1'b1, 5); add_seg(1'b0, len); add_seg(1'b1, 100);
      build_expected();
      run_trace();
      for (int t = 0; t < n; t++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_v[t] !== e) begin
          errors++;
          $display("FAIL press_boundary_%0d cycle %0d: got %b expected %b", len, t, obs_v[t], e);
        end
      end
      checks++;
      if (len == LONG - 1 && (obs_v[154] !== 5'b00001 || obs_v[104] !== 5'b10000)) begin
        errors++;
        $display("FAIL press_99: got %b/%b expected 10000/00001", obs_v[104], obs_v[154]);
      end else if (len == LONG && obs_v[105] !== 5'b10100) begin
        errors++;
        $display("FAIL press_100: got %b expected 10100", obs_v[105]);
      end
    end
  endtask

  task automatic test_gap_boundary();
    logic [4:0] e;
    for (int g = GAPT - 2; g <= GAPT; g += 2) begin
      start_reset(1'b1);
      clear_trace();
      add_seg(1'b1, 5); add_seg(1'b0, 30); add_seg(1'b1, g); add_seg(1'b0, 30); add_seg(1'b1, 200);
      build_expected();
      run_trace();
      for (int t = 0; t < n; t++) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_v[t] !== e) begin
          errors++;
          $display("FAIL gap_boundary_%0d cycle %0d: got %b expected %b", g, t, obs_v[t], e);
        end
      end
      checks++;
      if (g == GAPT - 2 && obs_v[84] !== 5'b10010) begin
        errors++;
        $display("FAIL gap_48: got %b expected 10010", obs_v[84]);
      end else if (g == GAPT && (obs_v[85] !== 5'b00001 || obs_v[165] !== 5'b00001)) begin
        errors++;
        $display("FAIL gap_50: got %b/%b expected 00001/00001", obs_v[85], obs_v[165]);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] e;
    start_reset(1'b0);
    clear_trace();
    add_seg(1'b0, 120);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL low_at_release cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
    end
    // Cycle 120 carries a repeat pulse; an asynchronous reset must drop it at once.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({key_busy, repeat_pulse, long_press, double_click, short_press} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got %b expected 00000",
               {key_busy, repeat_pulse, long_press, double_click, short_press});
    end
    clear_trace();
    add_seg(1'b0, 150);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL after_mid_reset cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
    end
    checks++;
    if (obs_v[100] !== 5'b10100 || obs_v[120] !== 5'b11000 || obs_v[119] !== 5'b10000) begin
      errors++;
      $display("FAIL after_mid_reset_timing: got %b %b %b expected 10100 10000 11000",
               obs_v[100], obs_v[119], obs_v[120]);
    end
  endtask

  task automatic test_random();
    logic [4:0] e;
    int d, g;
    start_reset(1'b1);
    clear_trace();
    add_seg(1'b1, 3);
    for (int i = 0; i < 12; i++) begin
      d = ($urandom_range(0, 2) == 0) ? $urandom_range(LONG - 5, LONG + 5) : $urandom_range(1, 170);
      g = ($urandom_range(0, 2) == 0) ? $urandom_range(GAPT - 5, GAPT + 5) : $urandom_range(1, 120);
      add_seg(1'b0, d);
      add_seg(1'b1, g);
    end
    add_seg(1'b1, 250);
    build_expected();
    run_trace();
    for (int t = 0; t < n; t++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_v[t] !== e) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", t, obs_v[t], e);
      end
      checks++;
      if ($countones(obs_v[t][3:0]) > 1) begin
        errors++;
        $display("FAIL one_event cycle %0d: got %b expected at most one event", t, obs_v[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_double_click();
    test_long_repeat();
    test_press_boundary();
    test_gap_boundary();
    test_reset_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
